// File: rtl/dumper_pkg.sv
// dumper_pkg: shared FSM state type and UART frame constants for the RAM dumper
package dumper_pkg;
  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS = 8;
  typedef enum logic [3:0] {
    IDLE, REQ, WAIT, START_HI, SEND_HI, START_LO, SEND_LO, NEXT, DONE
  } state_t;
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 transmitter; start/byte_in launch a frame on tx, tx_busy while sending, tx_done in last stop-bit cycle
module uart_tx_byte
  import dumper_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  logic [BW-1:0] baud_q;
  logic [3:0] bit_q;
  logic [DATA_BITS-1:0] sh_q;
  logic tx_q, busy_q, bit_end;
  assign bit_end = baud_q == BW'(CLKS_PER_BIT - 1);
  assign tx_done = busy_q && bit_end && bit_q == 4'(FRAME_BITS - 1);
  assign tx = tx_q;
  assign tx_busy = busy_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_q <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
    end else if (!busy_q) begin
      if (start) begin
        busy_q <= 1'b1;
        tx_q   <= 1'b0;
        sh_q   <= byte_in;
        baud_q <= '0;
        bit_q  <= '0;
      end
    end else if (!bit_end) begin
      baud_q <= baud_q + 1'b1;
    end else begin
      baud_q <= '0;
      bit_q  <= bit_q + 1'b1;
      tx_q   <= sh_q[0];
      sh_q   <= {1'b1, sh_q[DATA_BITS-1:1]};
      if (tx_done) begin
        busy_q <= 1'b0;
        tx_q   <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/ram_uart_dumper.sv
// ram_uart_dumper: on enable_ram_read, reads RAM words 0..RAM_DEPTH-1 and sends each as two 8N1 bytes (high first) on uart_tx; busy/done report progress
module ram_uart_dumper
  import dumper_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int RAM_DEPTH    = 64,
  parameter int ADDR_W       = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_ram_read,
  input  logic [15:0]       data_from_ram,
  output logic [ADDR_W-1:0] address_to_ram,
  output logic              read_enable_to_ram,
  output logic              uart_tx,
  output logic              busy,
  output logic              done
);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0] word_q;
  logic tx_start, tx_busy, tx_done, last;
  logic [7:0] tx_byte;
  assign last = addr_q == ADDR_W'(RAM_DEPTH - 1);
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE:     state_d = enable_ram_read ? REQ : IDLE;
      REQ:      state_d = WAIT;
      WAIT:     state_d = START_HI;
      START_HI: state_d = SEND_HI;
      SEND_HI:  state_d = tx_done ? START_LO : SEND_HI;
      START_LO: state_d = SEND_LO;
      SEND_LO:  state_d = tx_done ? NEXT : SEND_LO;
      NEXT: begin
        state_d = last ? DONE : REQ;
        addr_d  = last ? addr_q : addr_q + 1'b1;
      end
      default:  state_d = state_q;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      if (state_q == WAIT) word_q <= data_from_ram;
    end
  end
  assign address_to_ram     = addr_q;
  assign read_enable_to_ram = state_q == REQ;
  assign tx_start           = state_q == START_HI || state_q == START_LO;
  assign tx_byte            = state_q == START_HI ? word_q[15:8] : word_q[7:0];
  assign busy               = !(state_q == IDLE || state_q == DONE) || tx_busy;
  assign done               = state_q == DONE;
  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk     (clk),
    .reset   (reset),
    .start   (tx_start),
    .byte_in (tx_byte),
    .tx      (uart_tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );
endmodule

// File: doc/ram_uart_dumper.md
# ram_uart_dumper

Drains data memory over a serial line once the CPU signals end of execution (`enable_ram_read`). It reads RAM addresses 0..RAM_DEPTH-1 through the read port the CPU releases at end of execution. Each 16-bit word is sent as two 8N1 UART bytes, high byte first. The block sits beside `CPU` at the top level; the top-level RAM address/read-enable mux selects this block whenever `enable_ram_read` is high.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868, clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2.
- `RAM_DEPTH`, 64, number of words dumped.
- `ADDR_W`, 6, RAM address width; RAM_DEPTH ≤ 2^ADDR_W.

Ports:
- `clk` input 1: single clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-high.
- `enable_ram_read` input 1: end-of-execution level from `CPU`; starts the dump.
- `data_from_ram` input 16: RAM read data, valid the cycle after a read request.
- `address_to_ram` output ADDR_W: RAM read address.
- `read_enable_to_ram` output 1: one-cycle read strobe.
- `uart_tx` output 1: serial line, idle high.
- `busy` output 1: dump in progress.
- `done` output 1: dump complete; sticky until reset.

## Operation
- Reset values: `uart_tx`=1, `address_to_ram`=0, `read_enable_to_ram`=0, `busy`=0, `done`=0. Word register=0, bit and baud counters=0, FSM=IDLE.
- FSM states and transitions:
  - IDLE: on `enable_ram_read`=1 and `done`=0, go to REQ.
  - REQ: drive `address_to_ram`=addr and `read_enable_to_ram`=1; go to WAIT.
  - WAIT: capture `data_from_ram` into the word register at the end of the cycle; go to START_HI.
  - START_HI: pulse `start` with byte=word[15:8]; go to SEND_HI.
  - SEND_HI: on `tx_done`, go to START_LO.
  - START_LO: pulse `start` with byte=word[7:0]; go to SEND_LO.
  - SEND_LO: on `tx_done`, go to NEXT.
  - NEXT: if addr==RAM_DEPTH-1, go to DONE; otherwise addr+1 and go to REQ.
  - DONE: terminal until reset.
- `busy`=1 in every state except IDLE and DONE. `done`=1 in DONE only.
- Exactly one dump per reset. In DONE, a high or toggling `enable_ram_read` is ignored. If `enable_ram_read` drops mid-dump, the dump continues to the end.
- `read_enable_to_ram` is high only in REQ. `address_to_ram` holds the current addr at all times.
- Frame format: start bit 0, data bits b0..b7 (LSB first), stop bit 1. Each bit lasts exactly CLKS_PER_BIT cycles. No parity.
- Addr counter is ADDR_W bits and stops at RAM_DEPTH-1; it never wraps.

## Timing
- RAM read latency is 1 cycle: the address is driven in REQ and the data is sampled at the end of WAIT.
- IDLE samples `enable_ram_read`=1 in cycle e. REQ runs in cycle e+1, and `busy` goes high in e+1.
- Sub-module frame timing:
  - `start` is sampled in cycle s.
  - `uart_tx` goes low from cycle s+1 for 10·CLKS_PER_BIT cycles.
  - `tx_done` pulses for one cycle in the last cycle of the stop bit.
- Gaps on the line:
  - Between the high and low byte of a word: exactly 1 extra idle-high cycle (START_LO).
  - Between words: exactly 4 extra idle-high cycles (NEXT, REQ, WAIT, START_HI).
- One word takes 20·CLKS_PER_BIT+5 cycles.
- `done` rises at cycle e + RAM_DEPTH·(20·CLKS_PER_BIT+5) + 1, and `busy` falls in the same cycle.
- Reset during a dump: at the first edge with `reset`=1, all outputs take their reset values, so `uart_tx`=1 from the next cycle even mid-bit. The partial frame is abandoned. After release, a new dump starts as soon as `enable_ram_read`=1.
- `start` while the sub-module is busy never occurs by construction. The sub-module ignores it if it does.

## Structure
- Shared package `dumper_pkg`:
  - FSM state enum (IDLE, REQ, WAIT, START_HI, SEND_HI, START_LO, SEND_LO, NEXT, DONE).
  - Constants FRAME_BITS=10 and DATA_BITS=8.
- Sub-module `uart_tx_byte`:
  - Owns the baud counter (width $clog2(CLKS_PER_BIT)), the 4-bit bit index and the shift register.
  - Ports: `clk`, `reset`, `start`, `byte_in`[7:0], `tx`, `tx_busy`, `tx_done`.
- The top FSM owns the addr counter, the word register and the RAM strobe.

## Test plan
All scenarios use CLKS_PER_BIT=4, RAM_DEPTH=64 and a behavioural 1-cycle-latency RAM model preloaded with mem[i]=16'hA500+i, except where noted.
- Reset state: hold `reset` 3 cycles → `uart_tx`=1, `busy`=0, `done`=0, `read_enable_to_ram`=0, `address_to_ram`=0.
- First word: mem[0]=16'hA55A; raise `enable_ram_read` → `read_enable_to_ram` high for 1 cycle at addr 0. Line decodes 0xA5 then 0x5A; the first serial bits are 0,1,0,1,0,0,1,0,1,1. One idle cycle between the two frames.
- Full dump: the decoded stream is 128 bytes, A5 00 A5 01 … A5 3F. `done` rises exactly 5441 cycles after the sampling cycle and `read_enable_to_ram` pulses exactly 64 times. Every inter-word gap is 4 cycles.
- No retrigger: after `done`, toggle `enable_ram_read` 10 times → `uart_tx` stays 1, no RAM strobes, and `done` stays 1.
- Mid-dump reset: assert `reset` for 1 cycle during a data bit of word 5 → `uart_tx`=1 on the next cycle and `address_to_ram`=0. With `enable_ram_read` held high, the dump restarts from addr 0.
- Early deassert: drop `enable_ram_read` after 2 cycles → the full 64-word dump still completes and `done` rises.
